// File: rtl/seq_det_pkg.sv
// Shared constants for the serial sequence detectors.
package seq_det_pkg;

    localparam logic MODE_MOORE = 1'b0;
    localparam logic MODE_MEALY = 1'b1;

    localparam logic FOUND    = 1'b1;
    localparam logic NOTFOUND = 1'b0;

endpackage

// File: rtl/seq_detector_param_if.sv
// Stream, control and status bundle for seq_detector_param.
interface seq_detector_param_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               x;
    logic               valid;
    logic               load;
    logic [PAT_LEN-1:0] pattern_in;
    logic               overlap;
    logic               mode;
    logic               clr_count;
    logic               y;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    modport master (
        output x, valid, load, pattern_in, overlap, mode, clr_count,
        input  y, match_count, count_sat
    );

    modport slave (
        input  x, valid, load, pattern_in, overlap, mode, clr_count,
        output y, match_count, count_sat
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that holds at all-ones; clr takes priority over inc.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    assign sat = &count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector with overlap/non-overlap and Moore/Mealy output.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN   = 4,
    parameter int                 CNT_W     = 8,
    parameter logic [PAT_LEN-1:0] RESET_PAT = PAT_LEN'(4'b1011)
) (
    input  logic              clk,
    input  logic              reset,
    seq_detector_param_if.slave bus
);

    localparam int             FW       = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN);
    localparam logic [FW-1:0]  FILL_THR = FW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pattern_q;
    // Only PAT_LEN-1 past bits ever take part in a compare, so only those are kept.
    logic [PAT_LEN-2:0] hist_q;
    logic [FW-1:0]      fill_q;
    logic [FW-1:0]      fill_n;
    logic [PAT_LEN-1:0] window;
    logic               hit;
    logic               y_q;

    assign window = {hist_q, bus.x};

    always_comb begin
        hit = NOTFOUND;
        if (bus.valid && !bus.load && (fill_q >= FILL_THR) && (window == pattern_q)) begin
            hit = FOUND;
        end
    end

    always_comb begin
        fill_n = fill_q;
        if (hit && !bus.overlap) begin
            fill_n = '0;
        end else if (fill_q != FILL_MAX) begin
            fill_n = fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q <= RESET_PAT;
            hist_q    <= '0;
            fill_q    <= '0;
            y_q       <= 1'b0;
        end else begin
            y_q <= hit;
            if (bus.load) begin
                pattern_q <= bus.pattern_in;
                hist_q    <= '0;
                fill_q    <= '0;
            end else if (bus.valid) begin
                hist_q <= window[PAT_LEN-2:0];
                fill_q <= fill_n;
            end
        end
    end

    assign bus.y = (bus.mode == MODE_MEALY) ? hit : y_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clr_count),
        .inc   (hit),
        .count (bus.match_count),
        .sat   (bus.count_sat)
    );

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parameterised serial bit-sequence detector, the successor to the fixed 4-bit pattern FSM.
- Pattern and length are programmable, with a runtime load.
- Overlapping or non-overlapping match mode, selected at runtime.
- Moore (registered) or Mealy (same-cycle) output, selected at runtime.
- Saturating match counter.
- Sits between a serial input stream and control/status logic that needs a match pulse and a match tally.

Parameters:
PAT_LEN, 4, pattern length in bits (2..16); first received bit is compared against pattern MSB
CNT_W, 8, width of match counter
RESET_PAT, 4'b1011, pattern value after reset (PAT_LEN bits)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
x  input  1  serial data bit
valid  input  1  x is consumed on this rising edge when 1
load  input  1  load pattern_in into pattern register
pattern_in  input  PAT_LEN  new pattern, MSB is first bit expected
overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match
mode  input  1  0 = Moore, 1 = Mealy
clr_count  input  1  synchronous clear of match_count
y  output  1  match indication
match_count  output  CNT_W  number of matches, saturating
count_sat  output  1  match_count is at all-ones

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - pattern register = RESET_PAT, history = 0, fill = 0, y_q = 0, match_count = 0.
  - Consequently y = 0 and count_sat = 0 while reset is held.
- State:
  - hist[PAT_LEN-1:0]: newest bit in LSB.
  - fill: count of bits accepted since reset, load or non-overlap match; saturates at PAT_LEN.
- hit (combinational) = valid & !load & (fill >= PAT_LEN-1) & ({hist[PAT_LEN-2:0], x} == pattern).
- Per rising edge:
  - If load: pattern <= pattern_in, hist <= 0, fill <= 0, y_q <= 0. The valid bit in that cycle is discarded; load wins.
  - Else if valid: hist <= {hist[PAT_LEN-2:0], x}. Then fill <= 0 if (hit & !overlap); otherwise fill <= min(fill+1, PAT_LEN).
  - If valid=0 and load=0: hist and fill hold. Gaps in valid do not break a sequence.
- Output y:
  - Moore (mode=0): y = y_q, where y_q <= hit each edge. One-cycle pulse in the cycle after the completing bit; latency 1.
  - Mealy (mode=1): y = hit, asserted combinationally in the same cycle as the completing bit; latency 0.
  - mode is sampled continuously. Switching mode mid-stream changes only the y source, never detection state.
  - A Moore pulse pending from the previous cycle is visible only while mode=0.
- Counter (sub-module):
  - clr_count has priority: match_count <= 0, and a hit in the same cycle is not counted.
  - Else, on hit: match_count <= match_count+1, holding at 2^CNT_W-1.
  - count_sat = &match_count.
  - hit is counted independently of mode.
- Boundary cases:
  - Fewer than PAT_LEN bits since clear: no match, even if the stale history would compare equal.
  - Back-to-back matches with overlap=1: y can assert on consecutive accepted bits, e.g. pattern 1111 with a stream of 1s.
  - overlap is sampled in the cycle of the hit.
  - Reset mid-sequence discards partial progress; the next match requires PAT_LEN fresh bits.

Decomposition:
- Shared package seq_det_pkg:
  - MODE_MOORE = 1'b0, MODE_MEALY = 1'b1.
  - FOUND = 1'b1, NOTFOUND = 1'b0 (replacing the old `define constants).
- One sub-module: sat_counter.
  - Parameters: CNT_W.
  - Ports: clk, reset, clr, inc, count, sat.
  - Reused later by other detectors.

Test Plan:
1. Default pattern 1011, overlap=1, mode=0; bits 1,0,1,1,0,1,1 with valid=1 every cycle -> y pulses the cycle after bit 4 and after bit 7; match_count=2.
2. Same stream, overlap=0 -> single y pulse after bit 4; bits 5-7 (0,1,1) give no match; match_count=1.
3. mode=1, stream 1,0,1,1 -> y=1 combinationally during bit-4 cycle, 0 otherwise; mode=0 replay -> pulse shifted one cycle later.
4. load pattern_in=4'b0111 mid-stream after bits 1,0 -> history cleared; next 0,1,1,1 -> match; the prior 1,0 does not contribute; the bit in the load cycle is ignored.
5. CNT_W=2, pattern 1111, overlap=1, eight 1s -> 5 hits, match_count stops at 3, count_sat=1; clr_count together with a hit -> match_count=0.
6. Assert reset low after bits 1,0,1 -> y=0, count 0; then 1 alone -> no match; full 1,0,1,1 -> match. Also insert valid=0 gaps inside 1,0,1,1 -> match still detected.
